// File: rtl/fetch_unit.sv
// fetch_unit: PC + 1-cycle imem reads into a 2-entry valid/ready FIFO; `define FETCH_COUNT_EN adds a 16-bit pop counter
module fetch_unit #(
    parameter int INSTRUCTION_SIZE = 16,
    parameter int PC_WIDTH = INSTRUCTION_SIZE - 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    output logic imem_en,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
    input  logic jump_en,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic dec_ready,
    output logic instr_valid,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic [PC_WIDTH-1:0] instr_pc
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);
    logic [PC_WIDTH-1:0] pc_q, pc_d, tag_q, tag_d, hold_pc_q, hold_pc_d;
    logic [INSTRUCTION_SIZE-1:0] hold_instr_q, hold_instr_d;
    logic [INSTRUCTION_SIZE-1:0] data_q [FIFO_DEPTH];
    logic [INSTRUCTION_SIZE-1:0] data_d [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] addr_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] addr_d [FIFO_DEPTH];
    logic [1:0] count_q, count_d;
    logic inflight_q, inflight_d, rd_q, rd_d, wr_q, wr_d, push, pop;

    always_comb begin
        instr_valid = count_q != 2'd0;
        pop = instr_valid && dec_ready;
        push = inflight_q && !jump_en;
        // credit: buffered + in-flight words after this cycle's pop must leave room for one more
        imem_en = !rst && !jump_en && (int'(count_q) + int'(inflight_q) - int'(pop) < FIFO_DEPTH);
        imem_addr = pc_q;
        pc_d = jump_en ? jump_addr : (imem_en ? pc_q + PC_WIDTH'(1) : pc_q);
        inflight_d = imem_en;
        tag_d = imem_en ? pc_q : tag_q;
        rd_d = jump_en ? wr_q : rd_q ^ pop;
        wr_d = wr_q ^ push;
        count_d = jump_en ? 2'd0 : count_q + 2'(push) - 2'(pop);
        data_d = data_q;
        addr_d = addr_q;
        if (push) begin
            data_d[wr_q] = imem_rdata;
            addr_d[wr_q] = tag_q;
        end
        instruction = instr_valid ? data_q[rd_q] : hold_instr_q;
        instr_pc = instr_valid ? addr_q[rd_q] : hold_pc_q;
        hold_instr_d = instruction;
        hold_pc_d = instr_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
            tag_q <= '0;
            inflight_q <= 1'b0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            count_q <= 2'd0;
            hold_instr_q <= '0;
            hold_pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            tag_q <= tag_d;
            inflight_q <= inflight_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q <= hold_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        addr_q <= addr_d;
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 16'(pop);
        fetch_count = fetch_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) fetch_count_q <= '0;
        else fetch_count_q <= fetch_count_d;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus for fetch_unit, scored against a stream-level model of the fetch sequence
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst, jump_en, dec_ready, imem_en, instr_valid;
    logic [12:0] jump_addr, imem_addr, instr_pc;
    logic [15:0] imem_rdata, instruction;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .jump_en(jump_en),
        .jump_addr(jump_addr),
        .dec_ready(dec_ready),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .instr_pc(instr_pc)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [8192];

    // instruction memory; garbage on idle cycles so a spurious capture is visible
    always @(posedge clk) imem_rdata <= imem_en ? mem[imem_addr] : 16'($urandom);

    int checks = 0;
    int errors = 0;
    int outstanding = 0;
    int pops_total = 0;
    logic o_v, o_en, p_rst, p_jmp, p_stall;
    logic [12:0] o_pc, o_addr, p_pc, p_ja, exp_pc, next_issue;
    logic [15:0] o_i, p_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample, score against the expected fetch stream, advance the model.
    task automatic cyc(input logic r, input logic rdy, input logic jen, input logic [12:0] ja);
        rst = r;
        dec_ready = rdy;
        jump_en = jen;
        jump_addr = ja;
        #1;
        o_v = instr_valid;
        o_pc = instr_pc;
        o_i = instruction;
        o_en = imem_en;
        o_addr = imem_addr;
`ifdef FETCH_COUNT_EN
        chk("fetch_count", 32'(fetch_count), 32'(pops_total));
`endif
        if (p_rst) begin
            chk("rst_valid", 32'(o_v), 0);
            chk("rst_instr", 32'(o_i), 0);
            chk("rst_pc", 32'(o_pc), 0);
        end
        if (p_jmp) begin
            chk("jmp_flush_valid", 32'(o_v), 0);
            if (!r && !jen) begin
                chk("jmp_issue_en", 32'(o_en), 1);
                chk("jmp_issue_addr", 32'(o_addr), 32'(p_ja));
            end
        end
        if (r || jen) chk("blocked_en", 32'(o_en), 0);
        if (p_stall) begin
            chk("stall_valid", 32'(o_v), 1);
            chk("stall_pc", 32'(o_pc), 32'(p_pc));
            chk("stall_instr", 32'(o_i), 32'(p_i));
        end
        if (o_v && rdy && !r) begin
            chk("pop_pc", 32'(o_pc), 32'(exp_pc));
            chk("pop_instr", 32'(o_i), 32'(mem[exp_pc]));
            exp_pc++;
            outstanding--;
            pops_total++;
        end
        if (o_en) begin
            chk("issue_addr", 32'(o_addr), 32'(next_issue));
            next_issue++;
            outstanding++;
        end
        chk("credit_bound", 32'(outstanding >= 0 && outstanding <= 2), 1);
        p_rst = r;
        p_jmp = jen && !r;
        p_ja = ja;
        p_stall = o_v && !rdy && !jen && !r;
        p_pc = o_pc;
        p_i = o_i;
        if (r) begin
            exp_pc = '0;
            next_issue = '0;
            outstanding = 0;
            pops_total = 0;
        end else if (jen) begin
            exp_pc = ja;
            next_issue = ja;
            outstanding = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic r, j;
        logic [12:0] want;
        for (int i = 0; i < 8192; i++) mem[i] = 16'(i) + 16'h4000;
        {p_rst, p_jmp, p_stall} = '0;
        {p_pc, p_ja, p_i, exp_pc, next_issue} = '0;
        rst = 1'b1;
        dec_ready = 1'b0;
        jump_en = 1'b0;
        jump_addr = '0;
        @(posedge clk);
        #1;
        // reset release and first fetches
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            if (k == 0) chk("t1_first_en", 32'(o_en), 1);
            if (k < 2) chk("t1_latency", 32'(o_v), 0);
            else begin
                chk("t1_valid", 32'(o_v), 1);
                chk("t1_pc", 32'(o_pc), k - 2);
            end
            if (k == 2) chk("t1_instr", 32'(o_i), 32'h4000);
        end
        // stall with full FIFO, then resume
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, '0);
            chk("t2_valid_held", 32'(o_v), 1);
            if (k >= 1) chk("t2_full_noissue", 32'(o_en), 0);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            chk("t2_stream", 32'(o_v), 1);
        end
        // jump while two entries are buffered
        repeat (2) cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 13'h0123);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            if (k == 0) chk("t3_addr", 32'(o_addr), 32'h123);
            if (k < 2) chk("t3_flush", 32'(o_v), 0);
            if (k == 2) begin
                chk("t3_valid", 32'(o_v), 1);
                chk("t3_pc", 32'(o_pc), 32'h123);
                chk("t3_instr", 32'(o_i), 32'(mem[13'h123]));
            end
        end
        // PC wrap
        cyc(1'b0, 1'b1, 1'b1, 13'h1FFE);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            if (k >= 2) begin
                want = 13'h1FFE + 13'(k - 2);
                chk("t4_valid", 32'(o_v), 1);
                chk("t4_wrap_pc", 32'(o_pc), 32'(want));
            end
        end
        // reset with a word in flight and one buffered
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("t5_valid", 32'(o_v), 0);
        chk("t5_en", 32'(o_en), 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            if (k < 2) chk("t5_no_stale", 32'(o_v), 0);
            if (k == 2) begin
                chk("t5_restart_pc", 32'(o_pc), 0);
                chk("t5_restart_instr", 32'(o_i), 32'h4000);
            end
        end
        // random traffic
        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(99) == 0;
            j = !r && ($urandom_range(15) == 0);
            cyc(r, $urandom_range(3) != 0, j, 13'($urandom));
        end
`ifdef FETCH_COUNT_EN
        repeat (2) cyc(1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c < 200 && pops_total < 37; c++) cyc(1'b0, 1'b1, c == 10, 13'h0500);
        chk("t6_fetch_count", 32'(fetch_count), 37);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of deco_instructions.
- Holds the 13-bit program counter.
- Issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO and presents them to the decoder through a valid/ready handshake.
- Accepts jump redirects, typically from the J-type path, that flush in-flight and buffered work.

Parameters:
INSTRUCTION_SIZE, 16, instruction word width in bits.
PC_WIDTH, 13, PC and jump address width; equals INSTRUCTION_SIZE-3, matching the decoder's addr field.
FIFO_DEPTH, 2, output buffer entries; only the value 2 is supported.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
imem_en  out  1  read request to instruction memory this cycle.
imem_addr  out  PC_WIDTH  read address; equals pc.
imem_rdata  in  INSTRUCTION_SIZE  read data; valid the cycle after a request with imem_en=1.
jump_en  in  1  redirect request.
jump_addr  in  PC_WIDTH  redirect target.
dec_ready  in  1  decoder accepts the head instruction this cycle.
instr_valid  out  1  instruction/instr_pc are valid.
instruction  out  INSTRUCTION_SIZE  head instruction, fed to deco_instructions.
instr_pc  out  PC_WIDTH  address of the head instruction.

Behaviour:
Reset and counters:
- rst is sampled at the clock edge. While rst=1: pc=0, FIFO count=0, inflight=0, instr_valid=0, imem_en=0, instruction=0, instr_pc=0.
- A response pending when reset is asserted is discarded.
- pc increments modulo 2^PC_WIDTH, so 8191+1 wraps to 0.

Request issue:
- imem_en=1 when rst=0, jump_en=0, and (count + inflight - pop) < 2, where pop = instr_valid & dec_ready.
- On issue: inflight<=1, pc<=pc+1, tag register <= pc.
- With no issue: inflight<=0.

Response capture:
- When inflight=1 and no flush occurs that cycle, {tag, imem_rdata} is written to the FIFO tail at the edge.
- Latency: an issue in cycle n gives rdata in cycle n+1, and the entry is visible as instr_valid in cycle n+2.
- Example: first issue is the first cycle after rst deasserts (addr 0); first instr_valid is two cycles later.

Handshake:
- The head is consumed at an edge where instr_valid=1 and dec_ready=1.
- instruction and instr_pc stay stable while instr_valid=1 and dec_ready=0.
- dec_ready while instr_valid=0 has no effect.
- Simultaneous push and pop in one cycle: count is unchanged and order is preserved.
- Steady state with dec_ready=1 delivers one instruction per cycle.
- Full: count=2 and no pop means no issue. The credit rule prevents overflow; a push into a full FIFO is a design error, and the bench asserts that it never happens.
- Empty: instr_valid=0 and the outputs hold their last values.

Jump:
- jump_en=1 in cycle t, at the edge: FIFO count<=0, inflight<=0 (the returning word in cycle t+1 is dropped), pc<=jump_addr, imem_en=0 in cycle t.
- Jump has priority over issue, push and pop in cycle t; a pop handshake in cycle t still counts as consumed for the decoder.
- Cycle t+1: imem_addr=jump_addr, imem_en=1.
- Cycle t+3: instr_valid=1 with instr_pc=jump_addr.
- Back-to-back jumps: the last one wins.

State summary: fetch is a credit loop, not a named FSM. The state is pc, inflight, tag, the FIFO's 2 entries, and rd/wr pointers plus count.

Optional Feature:
Macro FETCH_COUNT_EN.
- Defined: adds output port fetch_count, out, 16 bits. It counts pops (instr_valid & dec_ready), reset to 0 by rst, wraps at 65535->0, and is not cleared by a jump.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. rst high 3 cycles, then dec_ready=1 with mem[i]=i+16'h4000 -> instr_valid first high 2 cycles after release with instr_pc=0, instruction=16'h4000; then one instruction per cycle, instr_pc 1,2,3,...
2. dec_ready=0 from cycle 5 to 10 -> count saturates at 2, imem_en=0 while full, outputs stable; on release, instr_pc continues sequentially with no gap or duplicate.
3. jump_en=1 with jump_addr=13'h0123 while the FIFO holds 2 entries -> next cycle instr_valid=0, imem_addr=13'h0123; 3 cycles after the jump instr_valid=1, instr_pc=13'h0123, instruction=mem[0x123].
4. Start at pc=13'h1FFE via a jump -> instr_pc sequence 1FFE, 1FFF, 0000, 0001.
5. rst asserted while inflight=1 and count=1 -> next cycle instr_valid=0 and imem_en=0; after release, fetch restarts at 0 and no stale word appears.
6. FETCH_COUNT_EN defined, 37 handshakes including one jump -> fetch_count=37.
